// File: rtl/wb_stage.sv
// wb_stage: write-back result select, HI/LO ownership, registered bypass copy and retire counter
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  validW,
  input  logic                  multu_enW,
  input  logic [1:0]            mf_selW,
  input  logic                  io_selW,
  input  logic                  dm2regW,
  input  logic                  jal_selW,
  input  logic                  we_regW,
  input  logic [DATA_W-1:0]     pc_plus_4W,
  input  logic [2*DATA_W-1:0]   alu_outW,
  input  logic [DATA_W-1:0]     rd_dmW,
  input  logic [DATA_W-1:0]     super_yW,
  input  logic [4:0]            rf_waW,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q,
  output logic                  fwd_we,
  output logic [4:0]            fwd_wa,
  output logic [DATA_W-1:0]     fwd_wd,
  output logic [CNT_W-1:0]      instret
);
  logic              mul_upd;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic [CNT_W-1:0]  instret_d;

  always_comb begin
    mul_upd   = validW & multu_enW;
    rf_wa     = jal_selW ? 5'(RA_IDX) : rf_waW;
    rf_wd     = jal_selW            ? pc_plus_4W :
                (mf_selW == 2'b10)  ? hi_q       :
                (mf_selW == 2'b01)  ? lo_q       :
                io_selW             ? super_yW   :
                dm2regW             ? rd_dmW     : alu_outW[DATA_W-1:0];
    // rst_n gates the write so nothing lands in the register file during reset
    rf_we     = validW & we_regW & (rf_wa != 5'd0) & rst_n;
    hi_d      = mul_upd ? alu_outW[2*DATA_W-1:DATA_W] : hi_q;
    lo_d      = mul_upd ? alu_outW[DATA_W-1:0] : lo_q;
    instret_d = instret + CNT_W'(validW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      fwd_we  <= 1'b0;
      fwd_wa  <= '0;
      fwd_wd  <= '0;
      instret <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      fwd_we  <= rf_we;
      fwd_wa  <= rf_wa;
      fwd_wd  <= rf_wd;
      instret <= instret_d;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a behavioural model of write-back
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        validW, multu_enW, io_selW, dm2regW, jal_selW, we_regW;
  logic [1:0]  mf_selW;
  logic [31:0] pc_plus_4W, rd_dmW, super_yW;
  logic [63:0] alu_outW;
  logic [4:0]  rf_waW;
  logic        rf_we, fwd_we, s_rf_we, s_fwd_we;
  logic [4:0]  rf_wa, fwd_wa, s_rf_wa, s_fwd_wa;
  logic [31:0] rf_wd, hi_q, lo_q, fwd_wd, instret;
  logic [31:0] s_rf_wd, s_hi_q, s_lo_q, s_fwd_wd;
  logic [3:0]  s_instret;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi, m_lo, m_cnt, m_fwd_wd, e_wd;
  logic        m_fwd_we, e_we;
  logic [4:0]  m_fwd_wa, e_wa;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .validW(validW), .multu_enW(multu_enW), .mf_selW(mf_selW),
    .io_selW(io_selW), .dm2regW(dm2regW), .jal_selW(jal_selW), .we_regW(we_regW),
    .pc_plus_4W(pc_plus_4W), .alu_outW(alu_outW), .rd_dmW(rd_dmW), .super_yW(super_yW),
    .rf_waW(rf_waW), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .hi_q(hi_q), .lo_q(lo_q),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wd(fwd_wd), .instret(instret)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .validW(validW), .multu_enW(multu_enW), .mf_selW(mf_selW),
    .io_selW(io_selW), .dm2regW(dm2regW), .jal_selW(jal_selW), .we_regW(we_regW),
    .pc_plus_4W(pc_plus_4W), .alu_outW(alu_outW), .rd_dmW(rd_dmW), .super_yW(super_yW),
    .rf_waW(rf_waW), .rf_we(s_rf_we), .rf_wa(s_rf_wa), .rf_wd(s_rf_wd), .hi_q(s_hi_q),
    .lo_q(s_lo_q), .fwd_we(s_fwd_we), .fwd_wa(s_fwd_wa), .fwd_wd(s_fwd_wd), .instret(s_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    validW = 0; multu_enW = 0; mf_selW = 0; io_selW = 0; dm2regW = 0; jal_selW = 0;
    we_regW = 0; pc_plus_4W = 0; alu_outW = 0; rd_dmW = 0; super_yW = 0; rf_waW = 0;
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_cnt = 0; m_fwd_we = 0; m_fwd_wa = 0; m_fwd_wd = 0;
  endtask

  // Expected write-port values straight from the write-back rules
  task automatic expect_port();
    e_wa = jal_selW ? 5'd31 : rf_waW;
    if (jal_selW)            e_wd = pc_plus_4W;
    else if (mf_selW == 2)   e_wd = m_hi;
    else if (mf_selW == 1)   e_wd = m_lo;
    else if (io_selW)        e_wd = super_yW;
    else if (dm2regW)        e_wd = rd_dmW;
    else                     e_wd = alu_outW[31:0];
    e_we = rst_n && validW && we_regW && e_wa != 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".hi"}, hi_q, m_hi);
    chk({tag, ".lo"}, lo_q, m_lo);
    chk({tag, ".instret"}, instret, m_cnt);
    chk({tag, ".instret4"}, s_instret, m_cnt % 16);
    chk({tag, ".fwd_we"}, fwd_we, m_fwd_we);
    chk({tag, ".fwd_wa"}, fwd_wa, m_fwd_wa);
    chk({tag, ".fwd_wd"}, fwd_wd, m_fwd_wd);
  endtask

  // Check the port, take one edge, advance the model, check registered state
  task automatic step(input string tag);
    #1;
    expect_port();
    chk({tag, ".rf_we"}, rf_we, e_we);
    chk({tag, ".rf_wa"}, rf_wa, e_wa);
    chk({tag, ".rf_wd"}, rf_wd, e_wd);
    @(posedge clk);
    if (validW && multu_enW) begin
      m_hi = alu_outW[63:32];
      m_lo = alu_outW[31:0];
    end
    if (validW) m_cnt = m_cnt + 1;
    m_fwd_we = e_we; m_fwd_wa = e_wa; m_fwd_wd = e_wd;
    #1;
    check_regs(tag);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    validW = 1; we_regW = 1; rf_waW = 5; alu_outW = 64'hFFFF_0000_1111_2222; multu_enW = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rf_we", rf_we, 0);
    chk("rst.rf_wd", rf_wd, 32'h1111_2222);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1;
    multu_enW = 0;
    step("rel");

    idle(); validW = 1; we_regW = 1; rf_waW = 8; alu_outW = 64'h0000_0000_1234_5678;
    step("alu");
    dm2regW = 1; rd_dmW = 32'hDEAD_BEEF;
    step("dm");
    io_selW = 1; super_yW = 32'h55;
    step("io");
    jal_selW = 1; pc_plus_4W = 32'h40;
    step("jal");

    idle(); validW = 1; multu_enW = 1; alu_outW = 64'hAAAA_BBBB_CCCC_DDDD;
    step("multu");
    idle(); validW = 1; we_regW = 1; mf_selW = 2'b10; rf_waW = 9;
    step("mfhi");
    mf_selW = 2'b01;
    step("mflo");
    mf_selW = 2'b11; alu_outW = 64'h7;
    step("mf11");
    multu_enW = 1; mf_selW = 0; alu_outW = 64'h0102_0304_0506_0708;
    step("multu_we");

    idle(); validW = 1; we_regW = 1; rf_waW = 0; alu_outW = 64'h99;
    step("wa0");
    idle(); multu_enW = 1; we_regW = 1; rf_waW = 3; alu_outW = 64'h1234_5678_9ABC_DEF0;
    step("bubble");
    idle();
    step("after_bubble");

    // asynchronous reset mid-cycle: clears without an edge
    validW = 1; we_regW = 1; rf_waW = 4;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("arst.rf_we", rf_we, 0);
    check_regs("arst");
    @(negedge clk);
    rst_n = 1;

    idle(); validW = 1;
    for (int i = 0; i < 15; i++) step("cnt");
    chk("wrap.pre", s_instret, 4'hF);
    step("cnt");
    chk("wrap.post", s_instret, 4'h0);

    for (int i = 0; i < 60; i++) begin
      validW     = ($urandom_range(0, 3) != 0);
      multu_enW  = ($urandom_range(0, 3) == 0);
      mf_selW    = 2'($urandom);
      io_selW    = ($urandom_range(0, 3) == 0);
      dm2regW    = ($urandom_range(0, 2) == 0);
      jal_selW   = ($urandom_range(0, 5) == 0);
      we_regW    = ($urandom_range(0, 3) != 0);
      pc_plus_4W = $urandom;
      alu_outW   = {$urandom, $urandom};
      rd_dmW     = $urandom;
      super_yW   = $urandom;
      rf_waW     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
